// File: rtl/status_message_tx_if.sv
// Byte stream handshake from the status formatter to the UART transmitter.
// The master drives data and valid. The slave drives ready.
interface status_message_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/status_message_tx.sv
// Sends "BT: 0xHHHH\n" / "SW: 0xHHHH\n" whenever switch or button state
// changes, after reset, and on an optional periodic refresh.
module status_message_tx #(
    parameter int SWITCH_COUNT   = 16,
    parameter int BUTTON_COUNT   = 5,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ena,
    input  logic [SWITCH_COUNT-1:0] switch_in,
    input  logic [BUTTON_COUNT-1:0] button_in,
    status_message_tx_if.master     tx,
    output logic                    busy
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [SWITCH_COUNT-1:0] sw_last_q, sw_last_d;
    logic [BUTTON_COUNT-1:0] bt_last_q, bt_last_d;
    logic                    sw_pend_q, sw_pend_d;
    logic                    bt_pend_q, bt_pend_d;
    logic [15:0]             snap_q, snap_d;
    logic                    sel_q, sel_d;
    logic [3:0]              idx_q, idx_d;
    logic [CW-1:0]           ref_cnt_q, ref_cnt_d;
    logic                    refresh_tc;
    logic [7:0]              tx_byte;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        state_d    = state_q;
        sw_last_d  = sw_last_q;
        bt_last_d  = bt_last_q;
        snap_d     = snap_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        ref_cnt_d  = '0;
        refresh_tc = 1'b0;

        if (REFRESH_CYCLES != 0 && ena) begin
            if (ref_cnt_q == CW'(REFRESH_CYCLES - 1))
                refresh_tc = 1'b1;
            else
                ref_cnt_d = ref_cnt_q + 1'b1;
        end

        // Compare against the last value sent, so mid-message edits re-arm.
        sw_pend_d = sw_pend_q | (switch_in != sw_last_q) | refresh_tc;
        bt_pend_d = bt_pend_q | (button_in != bt_last_q) | refresh_tc;

        unique case (state_q)
            IDLE: begin
                if (ena && bt_pend_q) begin
                    sel_d     = 1'b1;
                    snap_d    = 16'(button_in);
                    bt_last_d = button_in;
                    bt_pend_d = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = SEND;
                end else if (ena && sw_pend_q) begin
                    sel_d     = 1'b0;
                    snap_d    = 16'(switch_in);
                    sw_last_d = switch_in;
                    sw_pend_d = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx.tx_ready) begin
                    if (idx_q == 4'd10) begin
                        idx_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        if (state_q == SEND) begin
            unique case (idx_q)
                4'd0:    tx_byte = sel_q ? 8'h42 : 8'h53;
                4'd1:    tx_byte = sel_q ? 8'h54 : 8'h57;
                4'd2:    tx_byte = 8'h3A;
                4'd3:    tx_byte = 8'h20;
                4'd4:    tx_byte = 8'h30;
                4'd5:    tx_byte = 8'h78;
                4'd6:    tx_byte = hex(snap_q[15:12]);
                4'd7:    tx_byte = hex(snap_q[11:8]);
                4'd8:    tx_byte = hex(snap_q[7:4]);
                4'd9:    tx_byte = hex(snap_q[3:0]);
                4'd10:   tx_byte = 8'h0A;
                default: tx_byte = 8'h00;
            endcase
        end
    end

    assign tx.tx_data  = tx_byte;
    assign tx.tx_valid = (state_q == SEND);
    assign busy        = (state_q == SEND);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sw_last_q <= '0;
            bt_last_q <= '0;
            sw_pend_q <= 1'b1;
            bt_pend_q <= 1'b1;
            snap_q    <= '0;
            sel_q     <= 1'b0;
            idx_q     <= 4'd0;
            ref_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sw_last_q <= sw_last_d;
            bt_last_q <= bt_last_d;
            sw_pend_q <= sw_pend_d;
            bt_pend_q <= bt_pend_d;
            snap_q    <= snap_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            ref_cnt_q <= ref_cnt_d;
        end
    end

endmodule
